// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS-32 control path: opcodes, functs,
// AluOp codes (also used by the ALU), datapath mux encodings, FSM states.
// Ports: none (package only).
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type functs (IR[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // AluOp codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    // alu_src_b select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // pc_source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    // What the ALU is being asked to do in the current state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
    } alu_cls_t;

    function automatic logic is_r_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
            FN_OR, FN_XOR, FN_NOR, FN_SLT: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_i_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_op_dec.sv
// AluOp decoder: maps (opcode, funct, ALU class of current state) to alu_op
// and the immediate zero-extend select. Purely combinational.
// Ports: opcode/funct from IR, alu_cls from FSM -> alu_op, ext_zero.
module mips_alu_op_dec
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  alu_cls_t   alu_cls,
    output logic [3:0] alu_op,
    output logic       ext_zero
);

    always_comb begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
        case (alu_cls)
            ALU_CLS_SUB: alu_op = ALU_SUB;
            ALU_CLS_R: begin
                case (funct)
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    default:         alu_op = ALU_ADD;
                endcase
            end
            ALU_CLS_I: begin
                case (opcode)
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
                    OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS-32 control FSM: sequences fetch/decode/execute/mem/writeback
// and drives datapath selects/enables; waits on mem_ready in FETCH/MEM_RD/MEM_WR.
// Ports: clk, rst, opcode, funct, zf, mem_ready in; datapath controls, instr_done, illegal out.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zf,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal
);

    state_t   state, next_state;
    alu_cls_t alu_cls;
    logic     illegal_q;
    logic     decode_illegal;
    logic [3:0] dec_alu_op;
    logic       dec_ext_zero;

    mips_alu_op_dec u_alu_op_dec (
        .opcode   (opcode),
        .funct    (funct),
        .alu_cls  (alu_cls),
        .alu_op   (dec_alu_op),
        .ext_zero (dec_ext_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (decode_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state     = state;
        decode_illegal = 1'b0;
        alu_cls        = ALU_CLS_ADD;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_or_d         = 1'b0;
        ir_write       = 1'b0;
        pc_en          = 1'b0;
        pc_source      = PCSRC_ALU;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_REG;
        reg_write      = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        instr_done     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = SRCB_BOFF;
                if (opcode == OP_LW || opcode == OP_SW)
                    next_state = S_MEM_ADDR;
                else if (opcode == OP_RTYPE && is_r_funct(funct))
                    next_state = S_R_EXEC;
                else if (is_i_op(opcode))
                    next_state = S_I_EXEC;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    next_state = S_BRANCH;
                else if (opcode == OP_J)
                    next_state = S_JUMP;
                else begin
                    next_state     = S_TRAP;
                    decode_illegal = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_cls    = ALU_CLS_R;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_cls    = ALU_CLS_I;
                next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_cls    = ALU_CLS_SUB;
                pc_source  = PCSRC_ALUOUT;
                pc_en      = (opcode == OP_BEQ) ? zf : ~zf;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                if (!RESET_TRAP) next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // The state register is already FETCH during reset, so the Moore
        // decodes must be forced off explicitly to keep outputs quiet.
        if (rst) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            pc_source  = PCSRC_ALU;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_REG;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign alu_op   = rst ? ALU_ADD : dec_alu_op;
    assign ext_zero = dec_ext_zero & ~rst;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zf, mem_ready;

    logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a, ext_zero, reg_write, reg_dst, mem_to_reg, instr_done, illegal;
    logic [3:0] alu_op;

    logic       t_mem_read, t_mem_write, t_i_or_d, t_ir_write, t_pc_en;
    logic [1:0] t_pc_source, t_alu_src_b;
    logic       t_alu_src_a, t_ext_zero, t_reg_write, t_reg_dst, t_mem_to_reg, t_instr_done, t_illegal;
    logic [3:0] t_alu_op;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.RESET_TRAP(1'b0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zf(zf), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal)
    );

    mips_mc_ctrl #(.RESET_TRAP(1'b1)) dut_t (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zf(zf), .mem_ready(mem_ready),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .i_or_d(t_i_or_d), .ir_write(t_ir_write),
        .pc_en(t_pc_en), .pc_source(t_pc_source), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
        .ext_zero(t_ext_zero), .alu_op(t_alu_op), .reg_write(t_reg_write), .reg_dst(t_reg_dst),
        .mem_to_reg(t_mem_to_reg), .instr_done(t_instr_done), .illegal(t_illegal)
    );

    wire [19:0] out_vec = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                           alu_src_b, ext_zero, alu_op, reg_write, reg_dst, mem_to_reg,
                           instr_done, illegal};
    wire [19:0] t_vec   = {t_mem_read, t_mem_write, t_i_or_d, t_ir_write, t_pc_en, t_pc_source,
                           t_alu_src_a, t_alu_src_b, t_ext_zero, t_alu_op, t_reg_write, t_reg_dst,
                           t_mem_to_reg, t_instr_done, t_illegal};

    // ---------------- reference model (instruction-level) ----------------
    function automatic int base_lat(input logic [5:0] op);
        if (op == 6'h23) return 5;
        if (op == 6'h04 || op == 6'h05 || op == 6'h02) return 3;
        return 4;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                       6'h22, 6'h23: return 4'b0010;
                       6'h24:        return 4'b0100;
                       6'h25:        return 4'b0101;
                       6'h26:        return 4'b0110;
                       6'h27:        return 4'b0111;
                       6'h2A:        return 4'b1010;
                       default:      return 4'b0000;
                   endcase
            6'h0A:        return 4'b1010;
            6'h0C:        return 4'b0100;
            6'h0D:        return 4'b0101;
            6'h0E:        return 4'b0110;
            6'h04, 6'h05: return 4'b0010;
            default:      return 4'b0000;
        endcase
    endfunction

    // Runs one instruction from FETCH with a memory that stalls fw cycles on
    // the fetch and dw cycles on the data access, then checks the trace.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw,
                             input logic z, input logic exp_ill, input string name);
        int cyc = 0, n_rd = 0, n_wr = 0, n_rw = 0, n_pc = 0, n_ir = 0, waited = 0, req = 0;
        int e_cyc, e_rd, e_wr, e_rw, e_pc;
        logic done = 1'b0, seen_ex = 1'b0, ex_ez = 1'b0, f_dst = 1'b0, f_m2r = 1'b0;
        logic [3:0] ex_alu = 4'h0;
        logic [1:0] f_pcs = 2'b00, e_pcs;
        logic is_lw, is_sw, is_br, wr_rf;
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2B);
        is_br = (op == 6'h04 || op == 6'h05);
        wr_rf = !(is_sw || is_br || op == 6'h02);
        opcode = op; funct = fn; zf = z;
        while (!done && cyc < 30) begin
            #1;
            if (mem_read || mem_write) begin
                if (waited < ((req == 0) ? fw : dw)) begin mem_ready = 1'b0; waited++; end
                else begin mem_ready = 1'b1; waited = 0; req++; end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            n_rd += int'(mem_read);
            n_wr += int'(mem_write);
            n_rw += int'(reg_write);
            n_pc += int'(pc_en);
            n_ir += int'(ir_write);
            if (alu_src_a) begin seen_ex = 1'b1; ex_alu = alu_op; ex_ez = ext_zero; end
            if (instr_done) begin done = 1'b1; f_dst = reg_dst; f_m2r = mem_to_reg; f_pcs = pc_source; end
            @(posedge clk);
        end
        e_cyc = base_lat(op) + fw + ((is_lw || is_sw) ? dw : 0);
        e_rd  = fw + 1 + (is_lw ? dw + 1 : 0);
        e_wr  = is_sw ? dw + 1 : 0;
        e_rw  = wr_rf ? 1 : 0;
        e_pc  = 1 + ((op == 6'h02) ? 1 : 0) + ((op == 6'h04 && z) ? 1 : 0) + ((op == 6'h05 && !z) ? 1 : 0);
        e_pcs = (op == 6'h02) ? 2'b10 : (is_br ? 2'b01 : 2'b00);

        n_checks++; if (done !== 1'b1) $display("FAIL %s done_timeout got %0b want 1", name, done); else n_pass++;
        n_checks++; if (cyc !== e_cyc) $display("FAIL %s cycles got %0d want %0d", name, cyc, e_cyc); else n_pass++;
        n_checks++; if (n_rd !== e_rd) $display("FAIL %s mem_read_cycles got %0d want %0d", name, n_rd, e_rd); else n_pass++;
        n_checks++; if (n_wr !== e_wr) $display("FAIL %s mem_write_cycles got %0d want %0d", name, n_wr, e_wr); else n_pass++;
        n_checks++; if (n_rw !== e_rw) $display("FAIL %s reg_write_cycles got %0d want %0d", name, n_rw, e_rw); else n_pass++;
        n_checks++; if (n_pc !== e_pc) $display("FAIL %s pc_en_cycles got %0d want %0d", name, n_pc, e_pc); else n_pass++;
        n_checks++; if (n_ir !== 1) $display("FAIL %s ir_write_cycles got %0d want 1", name, n_ir); else n_pass++;
        n_checks++; if (f_pcs !== e_pcs) $display("FAIL %s pc_source_final got %b want %b", name, f_pcs, e_pcs); else n_pass++;
        n_checks++; if (seen_ex !== (op != 6'h02)) $display("FAIL %s exec_seen got %0b want %0b", name, seen_ex, op != 6'h02); else n_pass++;
        if (seen_ex) begin
            n_checks++; if (ex_alu !== exp_alu(op, fn)) $display("FAIL %s alu_op got %b want %b", name, ex_alu, exp_alu(op, fn)); else n_pass++;
            n_checks++; if (ex_ez !== (op == 6'h0C || op == 6'h0D || op == 6'h0E)) $display("FAIL %s ext_zero got %0b want %0b", name, ex_ez, (op == 6'h0C || op == 6'h0D || op == 6'h0E)); else n_pass++;
        end
        if (wr_rf) begin
            n_checks++; if (f_dst !== (op == 6'h00)) $display("FAIL %s reg_dst got %0b want %0b", name, f_dst, op == 6'h00); else n_pass++;
            n_checks++; if (f_m2r !== is_lw) $display("FAIL %s mem_to_reg got %0b want %0b", name, f_m2r, is_lw); else n_pass++;
        end
        n_checks++; if (illegal !== exp_ill) $display("FAIL %s illegal got %0b want %0b", name, illegal, exp_ill); else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1; opcode = 6'($urandom); funct = 6'($urandom); zf = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_vec !== 20'h0) $display("FAIL reset_outputs got %h want 00000", out_vec); else n_pass++;
        n_checks++; if (t_vec !== 20'h0) $display("FAIL reset_outputs_trapcfg got %h want 00000", t_vec); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({mem_read, i_or_d, alu_src_b, alu_op} !== 8'b1_0_01_0000)
            $display("FAIL reset_fetch got %b want 10010000", {mem_read, i_or_d, alu_src_b, alu_op}); else n_pass++;
    endtask

    task automatic test_add;
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b0, "add");
    endtask

    task automatic test_lw_wait;
        run_instr(6'h23, 6'($urandom), 0, 2, 1'b0, 1'b0, "lw_wait2");
    endtask

    task automatic test_branch;
        run_instr(6'h04, 6'($urandom), 0, 0, 1'b1, 1'b0, "beq_taken");
        run_instr(6'h05, 6'($urandom), 0, 0, 1'b1, 1'b0, "bne_not_taken");
        run_instr(6'h04, 6'($urandom), 1, 0, 1'b0, 1'b0, "beq_not_taken");
        run_instr(6'h02, 6'($urandom), 0, 0, 1'b0, 1'b0, "j");
    endtask

    task automatic test_alu_ops;
        logic [5:0] fns [5];
        fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        foreach (fns[i]) run_instr(6'h00, fns[i], 0, 0, 1'b0, 1'b0, "r_funct");
        run_instr(6'h0D, 6'($urandom), 0, 0, 1'b0, 1'b0, "ori");
        run_instr(6'h0A, 6'($urandom), 0, 0, 1'b0, 1'b0, "slti");
    endtask

    task automatic test_random;
        logic [5:0] r_fns [9];
        logic [5:0] i_ops [6];
        logic [5:0] op, fn;
        r_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        i_ops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
        for (int n = 0; n < 40; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 5))
                0: begin op = 6'h00; fn = r_fns[$urandom_range(0, 8)]; end
                1: op = i_ops[$urandom_range(0, 5)];
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
                default: op = 6'h02;
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    task automatic test_trap;
        int bad = 0;
        opcode = 6'h3F; funct = 6'h20;
        #1 mem_ready = 1'b1;
        @(posedge clk);          // FETCH -> DECODE
        @(posedge clk);          // DECODE -> TRAP
        #2;
        n_checks++; if ({illegal, t_illegal} !== 2'b11) $display("FAIL trap_illegal got %b want 11", {illegal, t_illegal}); else n_pass++;
        n_checks++; if ({mem_read, t_mem_read, instr_done} !== 3'b000) $display("FAIL trap_quiet got %b want 000", {mem_read, t_mem_read, instr_done}); else n_pass++;
        @(posedge clk);
        mem_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (t_vec !== 20'h00001 || mem_read !== 1'b1 || illegal !== 1'b1) bad++;
            @(posedge clk);
        end
        n_checks++; if (bad !== 0) $display("FAIL trap_hold bad_cycles got %0d want 0", bad); else n_pass++;
        run_instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b1, "after_trap_sub");
        n_checks++; if ({t_illegal, t_mem_read} !== 2'b10) $display("FAIL trap_still got %b want 10", {t_illegal, t_mem_read}); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({illegal, t_illegal} !== 2'b00) $display("FAIL trap_reset_clear got %b want 00", {illegal, t_illegal}); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        opcode = 6'h2B; funct = 6'($urandom);
        #1 mem_ready = 1'b1;
        @(posedge clk);          // FETCH -> DECODE
        #1 mem_ready = 1'b0;
        @(posedge clk);          // -> MEM_ADDR
        @(posedge clk);          // -> MEM_WR
        #2;
        n_checks++; if (mem_write !== 1'b1) $display("FAIL midrst_pre mem_write got %0b want 1", mem_write); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (out_vec !== 20'h0) $display("FAIL midrst_outputs got %h want 00000", out_vec); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({mem_read, mem_write, reg_write, pc_en, instr_done} !== 5'b10000)
            $display("FAIL midrst_fetch got %b want 10000", {mem_read, mem_write, reg_write, pc_en, instr_done}); else n_pass++;
        @(posedge clk);          // still FETCH (mem_ready low)
        run_instr(6'h2B, 6'($urandom), 1, 1, 1'b0, 1'b0, "sw_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_add;
        test_lw_wait;
        test_branch;
        test_alu_ops;
        test_random;
        test_trap;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
